// File: rtl/event_bfm_pkg.sv
// Shared definitions for the event BFM scheduler.
//   EV_MAX_WIDTH  : width of the upd_data record field (event values are
//                   zero-extended to this width)
//   sched_state_e : scheduler FSM states
package event_bfm_pkg;

  localparam int unsigned EV_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    PRESENT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/event_bfm_rr_arb.sv
// Round-robin arbiter, purely combinational.
//   req : request vector, one bit per channel
//   ptr : index of the most recently served channel (it is checked last)
//   gnt : one-hot grant, zero when no request is set
//   idx : binary index of the granted channel (0 when no request is set)
module event_bfm_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] idx
);

  logic found;

  // Two passes replace the modulo rotation: first the channels above ptr,
  // then wrap around to 0..ptr, so ptr itself has the lowest priority.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (CW'(i) > ptr)) begin
        gnt[i] = 1'b1;
        idx    = CW'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (CW'(i) <= ptr)) begin
        gnt[i] = 1'b1;
        idx    = CW'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_bfm_sched.sv
// Event BFM scheduler: watches N_CH event vectors and emits one update
// record per detected change through a valid/ready handshake.
//   clk, rst   : clock, asynchronous active-high reset
//   ev, en     : channel event vectors (channel i at [i*WIDTH +: WIDTH]) and
//                per-channel enables
//   upd_*      : update record (valid/ready, channel, zero-extended data,
//                first-report flag)
//   pend       : per-channel pending status (combinational)
//   ovf,ovf_clr: sticky per-channel overflow flags and their bitwise clear
module event_bfm_sched
  import event_bfm_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   ev,
  input  logic [N_CH-1:0]         en,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [CW-1:0]           upd_chan,
  output logic [EV_MAX_WIDTH-1:0] upd_data,
  output logic                    upd_first,
  output logic [N_CH-1:0]         pend,
  output logic [N_CH-1:0]         ovf,
  input  logic [N_CH-1:0]         ovf_clr
);

  sched_state_e     state;
  logic [CW-1:0]    ptr;
  logic [CW-1:0]    chan_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] last [N_CH];
  logic [N_CH-1:0]  init;

  logic [WIDTH-1:0] ev_a [N_CH];
  logic [N_CH-1:0]  gnt;
  logic [CW-1:0]    g_idx;
  logic [WIDTH-1:0] ev_g;
  logic [N_CH-1:0]  ovf_set;
  logic             accept;

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      ev_a[i] = ev[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      pend[i] = en[i] & (init[i] | (ev_a[i] != last[i]));
    end
  end

  event_bfm_rr_arb #(
    .N  (N_CH),
    .CW (CW)
  ) u_arb (
    .req (pend),
    .ptr (ptr),
    .gnt (gnt),
    .idx (g_idx)
  );

  always_comb begin
    ev_g = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt[i]) ev_g = ev_a[i];
    end
  end

  assign upd_valid = (state == PRESENT);
  assign accept    = upd_valid & upd_ready;
  assign upd_chan  = chan_r;
  // init is all ones during reset, so the flag is qualified by valid to keep
  // it low whenever no record is presented.
  assign upd_first = upd_valid & init[chan_r];

  always_comb begin
    upd_data = '0;
    upd_data[WIDTH-1:0] = data_r;
  end

  // A granted channel moving away from the captured value is an overflow.
  always_comb begin
    ovf_set = '0;
    if (state == PRESENT && ev_a[chan_r] != data_r) ovf_set[chan_r] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= CW'(N_CH - 1);
      chan_r <= '0;
      data_r <= '0;
      ovf    <= '0;
      init   <= '1;
      for (int unsigned i = 0; i < N_CH; i++) begin
        last[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: state <= ARB;
        ARB: begin
          if (|pend) begin
            data_r <= ev_g;
            chan_r <= g_idx;
            state  <= PRESENT;
          end
        end
        PRESENT: begin
          if (upd_ready) begin
            ptr   <= chan_r;
            state <= ARB;
          end
        end
        default: state <= IDLE;
      endcase

      // Disabled channels track their input silently; an accept on the
      // granted channel overrides this, so it comes after.
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!en[i]) last[i] <= ev_a[i];
      end
      if (accept) begin
        last[chan_r] <= data_r;
        init[chan_r] <= 1'b0;
      end

      ovf <= (ovf & ~ovf_clr) | ovf_set;
    end
  end

endmodule

// File: tb/tb_event_bfm_sched.sv
// Self-checking bench for event_bfm_sched: directed scenarios followed by
// randomized traffic, checked by a scoreboard fed from a transaction-level
// reference model.
module tb_event_bfm_sched;

  localparam int NC = 4;
  localparam int W  = 16;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NC*W-1:0]   ev = '0;
  logic [NC-1:0]     en = '0;
  logic              upd_valid;
  logic              upd_ready = 1'b0;
  logic [CW-1:0]     upd_chan;
  logic [63:0]       upd_data;
  logic              upd_first;
  logic [NC-1:0]     pend;
  logic [NC-1:0]     ovf;
  logic [NC-1:0]     ovf_clr = '0;

  event_bfm_sched #(
    .N_CH  (NC),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ev        (ev),
    .en        (en),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_chan  (upd_chan),
    .upd_data  (upd_data),
    .upd_first (upd_first),
    .pend      (pend),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          chan;
    logic [63:0] data;
    bit          first;
  } rec_t;

  rec_t          exp_q[$];
  bit [W-1:0]    m_last [NC];
  bit            m_init [NC];
  int            m_ptr;
  bit            m_hold;
  bit            m_boot;
  int            m_chan;
  bit [W-1:0]    m_data;
  bit [NC-1:0]   m_ovf;

  function automatic logic [W-1:0] ev_of(input int c);
    return ev[c*W +: W];
  endfunction

  function automatic bit pend_of(input int c);
    return en[c] && (m_init[c] || (ev_of(c) != m_last[c]));
  endfunction

  function automatic logic [NC-1:0] model_pend();
    logic [NC-1:0] p;
    for (int i = 0; i < NC; i++) p[i] = pend_of(i);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_last[i] = '0;
      m_init[i] = 1'b1;
    end
    m_ptr  = NC - 1;
    m_hold = 1'b0;
    m_boot = 1'b1;
    m_chan = 0;
    m_data = '0;
    m_ovf  = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit [NC-1:0] set_v;
    bit          commit;
    rec_t        r;
    set_v  = '0;
    commit = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_hold) begin
      for (int k = 1; k <= NC; k++) begin
        int c;
        c = (m_ptr + k) % NC;
        if (pend_of(c)) begin
          m_hold  = 1'b1;
          m_chan  = c;
          m_data  = ev_of(c);
          r.chan  = c;
          r.data  = {48'h0, ev_of(c)};
          r.first = m_init[c];
          exp_q.push_back(r);
          break;
        end
      end
    end else begin
      if (ev_of(m_chan) != m_data) set_v[m_chan] = 1'b1;
      if (upd_ready) commit = 1'b1;
    end
    for (int i = 0; i < NC; i++) begin
      if (!en[i]) m_last[i] = ev_of(i);
    end
    if (commit) begin
      m_last[m_chan] = m_data;
      m_init[m_chan] = 1'b0;
      m_ptr          = m_chan;
      m_hold         = 1'b0;
    end
    m_ovf = (m_ovf & ~ovf_clr) | set_v;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("pend", {60'h0, pend}, {60'h0, model_pend()});
      check("ovf", {60'h0, ovf}, {60'h0, m_ovf});
      check("upd_valid", {63'h0, upd_valid}, {63'h0, m_hold});
      if (upd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_record: chan %0d data 0x%0h with no expected record", upd_chan, upd_data);
        end else begin
          check("upd_chan", {62'h0, upd_chan}, 64'(exp_q[0].chan));
          check("upd_data", upd_data, exp_q[0].data);
          check("upd_first", {63'h0, upd_first}, {63'h0, exp_q[0].first});
          if (upd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ev(input int c, input logic [W-1:0] v);
    ev[c*W +: W] = v;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_valid", {63'h0, upd_valid}, 64'h0);
    check("rst_chan", {62'h0, upd_chan}, 64'h0);
    check("rst_data", upd_data, 64'h0);
    check("rst_first", {63'h0, upd_first}, 64'h0);
    check("rst_ovf", {60'h0, ovf}, 64'h0);

    en        = '1;
    upd_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step(12);                      // four first-reports, chans 0..3

    set_ev(2, 16'h005A);           // single change, no contention
    step(6);

    set_ev(1, 16'h0011);           // leaves ptr at 1
    step(6);
    set_ev(1, 16'h0022);
    set_ev(3, 16'h0033);           // ch3 expected before ch1
    step(8);

    upd_ready = 1'b0;              // stall with overflow on ch0
    set_ev(0, 16'h0001);
    step(3);
    set_ev(0, 16'h0002);
    step(3);
    upd_ready = 1'b1;
    step(8);
    ovf_clr = 4'b0001;
    step(1);
    ovf_clr = '0;
    step(2);

    en[1] = 1'b0;                  // disabled channel tracks silently
    for (int i = 0; i < 4; i++) begin
      set_ev(1, 16'(16'h0100 + i));
      step(1);
    end
    en[1] = 1'b1;
    step(6);
    set_ev(1, 16'h0BEE);
    step(6);

    upd_ready = 1'b0;              // reset while a record is presented
    set_ev(2, 16'h0077);
    step(3);
    rst = 1'b1;
    #1;
    check("rst_drop_valid", {63'h0, upd_valid}, 64'h0);
    check("rst_drop_first", {63'h0, upd_first}, 64'h0);
    step(2);
    rst       = 1'b0;
    upd_ready = 1'b1;
    step(14);

    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 2) == 0) begin
        int c;
        c = $urandom_range(0, NC - 1);
        if ($urandom_range(0, 3) == 0) set_ev(c, 16'($urandom));
        else                           set_ev(c, 16'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 19) == 0) en[$urandom_range(0, NC - 1)] ^= 1'b1;
      upd_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = '0;
      if ($urandom_range(0, 7) == 0) ovf_clr = 4'($urandom);
      step(1);
    end

    ovf_clr   = '0;
    upd_ready = 1'b1;
    step(40);
    check("drain_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
